code_monitor: RTL and testbench
===============================

CODE_MONITOR -- requirements
Module: code_monitor

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: consecutive legal transitions needed to enter LOCKED (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8: width of err_cnt and lap_cnt.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port code_in, input, 3: upstream counter code; bit2=Q_C, bit1=Q_B, bit0=Q_A.
REQ-006 SHALL have port in_valid, input, 1: code_in is sampled on an edge only when high.
REQ-007 SHALL have port clr_cnt, input, 1: synchronous clear of err_cnt and lap_cnt.
REQ-008 SHALL have port state, output, 2: FSM state (HUNT=0, LOCKED=1, ERR=2).
REQ-009 SHALL have port locked, output, 1: high exactly when state==LOCKED.
REQ-010 SHALL have port err_pulse, output, 1: one-cycle pulse on an illegal transition detected in LOCKED.
REQ-011 SHALL have port lap_pulse, output, 1: one-cycle pulse on a completed lap in LOCKED.
REQ-012 SHALL have port err_cnt, output, CNT_W: saturating error count.
REQ-013 SHALL have port lap_cnt, output, CNT_W: wrapping lap count.

Function
REQ-014 SHALL define successor SUCC (code_in bits 2..0): 000->011, 011->010, 010->110, 110->111, 111->101, 101->100, 100->001, 001->011.
REQ-015 SHALL classify a valid sample as legal iff prev_vld==1 and code_in==SUCC(prev_code); a first sample (prev_vld==0) is neither legal nor illegal.
REQ-016 SHALL, on every valid sample, load prev_code<=code_in and set prev_vld<=1.
REQ-017 SHALL register all outputs; effects of a sample taken at edge k are visible after edge k (one-cycle latency).
REQ-018 SHALL, with in_valid low, hold state, prev_code, the counters and good_run, and drive err_pulse=lap_pulse=0.
REQ-019 SHALL, in HUNT: on a legal sample increment good_run; on reaching LOCK_CNT go to LOCKED and clear good_run; on an illegal sample clear good_run and stay in HUNT with no err_pulse.
REQ-020 SHALL, in LOCKED: stay on a legal sample; assert lap_pulse and increment lap_cnt modulo 2^CNT_W on the legal transition 001->011.
REQ-021 SHALL, in LOCKED: on an illegal sample (including any code_in==000) go to ERR, assert err_pulse, and increment err_cnt saturating at 2^CNT_W-1.
REQ-022 SHALL stay in ERR for exactly one cycle, then go to HUNT with good_run=0 regardless of in_valid; a sample taken in ERR only updates prev_code/prev_vld.
REQ-023 SHALL give clr_cnt priority: both counters read 0 after the edge, even if an increment was due; pulses still fire.
REQ-024 SHALL never assert err_pulse and lap_pulse in the same cycle.

Reset
REQ-025 SHALL, while rst is high, force immediately: state=HUNT, locked=0, err_pulse=0, lap_pulse=0, err_cnt=0, lap_cnt=0, prev_vld=0, prev_code=000, good_run=0.
REQ-026 SHALL treat the first valid sample after reset deassertion as the first sample (REQ-015), including mid-lap reset.

Structure
REQ-027 SHALL place the state encodings (HUNT/LOCKED/ERR) and the SUCC table in a shared package/header code_mon_pkg, reused by the upstream counter bench.
REQ-028 SHALL implement SUCC as one combinational sub-module code_succ (3-bit in, 3-bit out); FSM and counters stay in code_monitor.

Verification
REQ-029 SHALL cover lock: after reset, valid codes 000,011,010,110 -> locked=1 after the 4th sample edge; state=1.
REQ-030 SHALL cover lap: locked, feed 111,101,100,001,011 -> single lap_pulse after the 011 edge, lap_cnt=1, err_cnt=0.
REQ-031 SHALL cover error: locked at 010, feed 101 -> err_pulse 1 cycle, err_cnt=1, state 2 for one cycle then 0; then 100,001,011 -> locked=1 again.
REQ-032 SHALL cover saturation: with CNT_W=8, force 256 lock/error cycles -> err_cnt stays 255; with clr_cnt high on the next error edge -> err_cnt=0 and err_pulse=1.
REQ-033 SHALL cover gaps and reset: in_valid toggled low between codes of a lap -> identical counts; rst pulsed mid-cycle while locked -> outputs 0 immediately, first sample after release yields no err_pulse.

Source files
------------

// File: rtl/code_mon_pkg.sv
// rtl/code_mon_pkg.sv - shared state encodings and counter-code successor table
package code_mon_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        ERR    = 2'd2
    } mon_state_t;

    // A lap completes on this transition.
    localparam logic [2:0] LAP_FROM = 3'b001;
    localparam logic [2:0] LAP_TO   = 3'b011;

    // Code sequence of the upstream counter; 000 is an entry-only code and never a successor.
    function automatic logic [2:0] succ_code(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            3'b000:  nxt = 3'b011;
            3'b011:  nxt = 3'b010;
            3'b010:  nxt = 3'b110;
            3'b110:  nxt = 3'b111;
            3'b111:  nxt = 3'b101;
            3'b101:  nxt = 3'b100;
            3'b100:  nxt = 3'b001;
            3'b001:  nxt = 3'b011;
            default: nxt = 3'b011;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/code_succ.sv
// rtl/code_succ.sv - combinational successor lookup for the counter code
module code_succ
    import code_mon_pkg::*;
(
    input  logic [2:0] code,
    output logic [2:0] next_code
);

    assign next_code = succ_code(code);

endmodule

// File: rtl/code_monitor.sv
// rtl/code_monitor.sv - lock/lap/error monitor for the upstream counter code stream
module code_monitor
    import code_mon_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       code_in,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [1:0]       state,
    output logic             locked,
    output logic             err_pulse,
    output logic             lap_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] lap_cnt
);

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    mon_state_t state_q, state_d;
    logic [3:0] good_run_q, good_run_d;
    logic [2:0] prev_code;
    logic       prev_vld;
    logic [2:0] expect_code;
    logic       judged;
    logic       legal;
    logic       err_hit;
    logic       lap_hit;

    code_succ u_succ (
        .code      (prev_code),
        .next_code (expect_code)
    );

    // A sample is only judged once a previous code exists.
    assign judged = in_valid && prev_vld;
    assign legal  = judged && (code_in == expect_code);

    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        err_hit    = 1'b0;
        lap_hit    = 1'b0;
        case (state_q)
            HUNT: begin
                if (legal) begin
                    if (good_run_q + 4'd1 == LOCK_TGT) begin
                        state_d    = LOCKED;
                        good_run_d = 4'd0;
                    end else begin
                        good_run_d = good_run_q + 4'd1;
                    end
                end else if (judged) begin
                    good_run_d = 4'd0;
                end
            end
            LOCKED: begin
                if (legal) begin
                    lap_hit = (prev_code == LAP_FROM) && (code_in == LAP_TO);
                end else if (in_valid) begin
                    // Covers 000 as well: it never follows any code.
                    state_d = ERR;
                    err_hit = 1'b1;
                end
            end
            ERR: begin
                state_d    = HUNT;
                good_run_d = 4'd0;
            end
            default: begin
                state_d    = HUNT;
                good_run_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            good_run_q <= 4'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            lap_pulse  <= 1'b0;
            prev_code  <= 3'b000;
            prev_vld   <= 1'b0;
            err_cnt    <= '0;
            lap_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            good_run_q <= good_run_d;
            locked     <= (state_d == LOCKED);
            err_pulse  <= err_hit;
            lap_pulse  <= lap_hit;
            if (in_valid) begin
                prev_code <= code_in;
                prev_vld  <= 1'b1;
            end
            // Clear wins over a same-cycle increment; the pulses are unaffected.
            if (clr_cnt) begin
                err_cnt <= '0;
                lap_cnt <= '0;
            end else begin
                if (err_hit && err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (lap_hit) begin
                    lap_cnt <= lap_cnt + 1'b1;
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_code_monitor.sv
// tb/tb_code_monitor.sv - scoreboard bench for code_monitor
module tb_code_monitor;

    localparam int LOCK = 3;

    logic       clk;
    logic       rst;
    logic [2:0] code_in;
    logic       in_valid;
    logic       clr_cnt;
    logic [1:0] state;
    logic       locked;
    logic       err_pulse;
    logic       lap_pulse;
    logic [7:0] err_cnt;
    logic [7:0] lap_cnt;

    code_monitor #(.LOCK_CNT(LOCK), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .clr_cnt   (clr_cnt),
        .state     (state),
        .locked    (locked),
        .err_pulse (err_pulse),
        .lap_pulse (lap_pulse),
        .err_cnt   (err_cnt),
        .lap_cnt   (lap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       lk;
        logic       ep;
        logic       lp;
        logic [7:0] ec;
        logic [7:0] lc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [2:0] succ_t [8];
    int         m_state;
    int         m_gr;
    logic [2:0] m_prev;
    logic       m_pvld;
    int         m_err;
    int         m_lap;
    logic [2:0] cur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_gr = 0; m_prev = 3'b000; m_pvld = 1'b0; m_err = 0; m_lap = 0;
        sb.delete();
    endtask

    task automatic step(input logic v, input logic [2:0] c, input logic clr);
        exp_t e;
        logic ok;
        e.ep = 1'b0;
        e.lp = 1'b0;
        if (m_state == 2) begin
            m_state = 0;
            m_gr    = 0;
        end else if (v && m_pvld) begin
            ok = (c == succ_t[m_prev]);
            if (m_state == 0) begin
                if (ok) begin
                    m_gr++;
                    if (m_gr == LOCK) begin m_state = 1; m_gr = 0; end
                end else m_gr = 0;
            end else if (ok) begin
                if (m_prev == 3'b001 && c == 3'b011) begin e.lp = 1'b1; m_lap = (m_lap + 1) % 256; end
            end else begin
                m_state = 2; e.ep = 1'b1;
                if (m_err < 255) m_err++;
            end
        end
        if (v) begin m_prev = c; m_pvld = 1'b1; end
        if (clr) begin m_err = 0; m_lap = 0; end
        e.st = 2'(m_state);
        e.lk = (m_state == 1);
        e.ec = 8'(m_err);
        e.lc = 8'(m_lap);
        sb.push_back(e);

        in_valid = v; code_in = c; clr_cnt = clr;
        @(posedge clk); #1;
        in_valid = 1'b0; clr_cnt = 1'b0;
        e = sb.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("locked", 32'(locked), 32'(e.lk));
        check("err_pulse", 32'(err_pulse), 32'(e.ep));
        check("lap_pulse", 32'(lap_pulse), 32'(e.lp));
        check("err_cnt", 32'(err_cnt), 32'(e.ec));
        check("lap_cnt", 32'(lap_cnt), 32'(e.lc));
        check("pulse_excl", 32'(err_pulse & lap_pulse), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        check({tag, "_lap_pulse"}, 32'(lap_pulse), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_lap_cnt"}, 32'(lap_cnt), 32'd0);
    endtask

    initial begin
        succ_t[0] = 3'b011; succ_t[3] = 3'b010; succ_t[2] = 3'b110; succ_t[6] = 3'b111;
        succ_t[7] = 3'b101; succ_t[5] = 3'b100; succ_t[4] = 3'b001; succ_t[1] = 3'b011;

        rst = 1'b1; in_valid = 1'b0; code_in = 3'b000; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // lock from reset
        step(1, 3'b000, 0); step(1, 3'b011, 0); step(1, 3'b010, 0);
        check("pre_lock", 32'(locked), 32'd0);
        step(1, 3'b110, 0);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_state", 32'(state), 32'd1);

        // one full lap
        step(1, 3'b111, 0); step(1, 3'b101, 0); step(1, 3'b100, 0); step(1, 3'b001, 0);
        step(1, 3'b011, 0);
        check("lap_pulse_011", 32'(lap_pulse), 32'd1);
        check("lap_cnt_1", 32'(lap_cnt), 32'd1);
        check("lap_err_cnt_0", 32'(err_cnt), 32'd0);

        // illegal 010 -> 101, ERR for one cycle, then relock
        step(1, 3'b010, 0);
        step(1, 3'b101, 0);
        check("err_pulse_hit", 32'(err_pulse), 32'd1);
        check("err_state", 32'(state), 32'd2);
        check("err_cnt_1", 32'(err_cnt), 32'd1);
        step(0, 3'b000, 0);
        check("err_to_hunt", 32'(state), 32'd0);
        check("err_pulse_once", 32'(err_pulse), 32'd0);
        step(1, 3'b100, 0); step(1, 3'b001, 0); step(1, 3'b011, 0);
        check("relock", 32'(locked), 32'd1);

        // lap with in_valid gaps between codes
        step(1, 3'b010, 0); step(0, 3'b000, 0); step(1, 3'b110, 0); step(0, 3'b111, 0);
        step(1, 3'b111, 0); step(0, 3'b000, 0); step(1, 3'b101, 0); step(1, 3'b100, 0);
        step(0, 3'b100, 0); step(1, 3'b001, 0); step(0, 3'b000, 0); step(1, 3'b011, 0);
        check("gap_lap_cnt", 32'(lap_cnt), 32'd2);
        check("gap_err_cnt", 32'(err_cnt), 32'd1);

        // saturation of err_cnt across 256 lock/error cycles
        cur = 3'b011;
        for (int i = 0; i < 256; i++) begin
            cur = succ_t[succ_t[cur]];
            step(1, cur, 0);
            step(0, 3'b000, 0);
            for (int j = 0; j < LOCK; j++) begin
                cur = succ_t[cur];
                step(1, cur, 0);
            end
        end
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        check("sat_locked", 32'(locked), 32'd1);
        cur = succ_t[succ_t[cur]];
        step(1, cur, 1);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_err_pulse", 32'(err_pulse), 32'd1);
        check("clr_lap_cnt", 32'(lap_cnt), 32'd0);
        step(0, 3'b000, 0);

        // relock, start a lap, then reset asynchronously mid-cycle
        for (int j = 0; j < LOCK; j++) begin
            cur = succ_t[cur];
            step(1, cur, 0);
        end
        step(1, succ_t[cur], 0);
        check("pre_rst_locked", 32'(locked), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 3'b101, 0);
        check("post_rst_no_err", 32'(err_pulse), 32'd0);
        check("post_rst_state", 32'(state), 32'd0);
        step(1, 3'b100, 0); step(1, 3'b001, 0); step(1, 3'b011, 0);
        check("post_rst_lock", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
